csr_unit: RTL
=============

Name: csr_unit

Overview:
Machine-mode CSR file for the NPC core, parametrised in XLEN.
- Supports CSRRW/CSRRS/CSRRC semantics and legality checking.
- Handles trap entry and mret, interrupt request generation with direct or vectored mtvec, and free-running mcycle/minstret counters.
- Sits beside the EXU/WBU: decode drives the CSR access, the commit stage drives trap, mret and retire events.

Parameters:
XLEN, 32, data width; legal values are 32 and 64.
VECTORED_EN, 1, 1 = mtvec MODE 1 (vectored) is supported; 0 = MODE is hardwired to 0.
HART_ID, 0, value returned by mhartid.

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
csr_op  input  2  00 none, 01 RW, 10 RS (set), 11 RC (clear)
csr_addr  input  12  CSR address
csr_wdata  input  XLEN  rs1 value or zero-extended uimm
csr_rdata  output  XLEN  old CSR value (combinational)
csr_illegal  output  1  access is illegal; no state change occurs
trap_valid  input  1  take an exception or interrupt this cycle
trap_cause  input  XLEN  mcause value; MSB = interrupt
trap_epc  input  XLEN  faulting or interrupted PC
trap_tval  input  XLEN  mtval value
mret  input  1  execute mret this cycle
retire  input  1  one instruction retired this cycle
mtip  input  1  timer interrupt pending (level)
meip  input  1  external interrupt pending (level)
trap_target  output  XLEN  PC to fetch after trap_valid
mret_target  output  XLEN  equals mepc
irq_req  output  1  an enabled interrupt is pending
irq_cause  output  XLEN  cause to present on trap_cause when irq_req is taken

Behaviour:
- Register set and addresses:
  - mstatus 0x300: MIE bit 3, MPIE bit 7, MPP 12:11 hardwired 11; all other bits read 0.
  - misa 0x301: read-only; reads RV32I/RV64I with the M-mode extension bits.
  - mie 0x304: bits 3, 7, 11 writable.
  - mtvec 0x305; mscratch 0x340.
  - mepc 0x341: bits 1:0 forced 0.
  - mcause 0x342; mtval 0x343.
  - mip 0x344: read-only; bit 7 = mtip, bit 11 = meip.
  - mcycle 0xB00 and minstret 0xB02: full 64-bit counters.
  - mcycleh 0xB80 and minstreth 0xB82: exist only when XLEN=32; give access to the high 32 bits.
  - mhartid 0xF14: reads HART_ID.
- Read path:
  - csr_rdata is combinational from csr_addr and returns the pre-write value.
  - csr_rdata = 0 when csr_op = 00 or the access is illegal.
- Write value:
  - RW: new = wdata.
  - RS: new = old | wdata.
  - RC: new = old & ~wdata.
  - Writes commit at the posedge.
  - RS/RC with wdata = 0 are not writes, so they are legal on read-only CSRs.
- csr_illegal = op != 00 AND (unimplemented address OR (a write occurs AND (addr[11:10] == 11 OR addr is misa/mip))).
  - Illegal accesses change no state.
- mtvec MODE:
  - Writes with MODE 2 or 3 store MODE 0.
  - When VECTORED_EN = 0, MODE is always 0.
- Counters:
  - mcycle increments by 1 every cycle out of reset.
  - minstret increments by 1 when retire = 1.
  - Both wrap from 2^64-1 to 0.
  - A CSR write to a counter half in the same cycle wins over the increment for that half. The other half keeps its value, with no carry into it.
- Trap entry (trap_valid = 1), applied at the posedge:
  - mepc <= trap_epc & ~3; mcause <= trap_cause; mtval <= trap_tval.
  - MPIE <= MIE; MIE <= 0; MPP <= 11.
- trap_target (combinational):
  - Default: {mtvec[XLEN-1:2], 00}.
  - If MODE = 1 and trap_cause MSB = 1: base + 4 * trap_cause[XLEN-2:0].
- mret, applied at the posedge:
  - MIE <= MPIE; MPIE <= 1; MPP stays 11.
  - mret_target = mepc, combinational.
- Interrupts:
  - irq_req = MIE & ((mie[11] & meip) | (mie[7] & mtip)).
  - irq_cause = MSB set | 11 if the external interrupt is enabled and pending, else MSB set | 7. External has priority over timer.
  - irq_cause = 0 when irq_req = 0.
  - Pending inputs are level-sensitive and are not latched.
- Priority within one cycle: rst > trap_valid > mret > CSR write.
  - A CSR write coincident with trap or mret is dropped, and csr_illegal is still reported.
  - Counters still increment during trap and mret cycles.
- Reset:
  - mstatus = 0x1800 (MPP = 11).
  - mie, mtvec, mscratch, mepc, mcause, mtval, mcycle, minstret = 0.
  - Outputs follow these values; irq_req = 0.
  - Reset mid-trap abandons the trap with no partial update.

Test Plan:
1. Reset, then CSRRW mtvec = 0x8000_0101 -> reads 0x8000_0101. CSRRW mtvec = 0x8000_0102 -> reads 0x8000_0100 (MODE 2 stores 0).
2. mstatus MIE = 1, trap_valid with cause 0xB, epc 0x8000_0046 -> mepc = 0x8000_0044, mcause = 0xB, mstatus = 0x1880, trap_target = mtvec base. Then mret -> mstatus = 0x1888, mret_target = 0x8000_0044.
3. mtvec = 0x8000_0001, MIE = 1, mie = 0x880, mtip = meip = 1 -> irq_req = 1, irq_cause = 0x8000_000B. Taking the trap -> trap_target = 0x8000_002C and irq_req drops to 0 (MIE = 0).
4. CSRRS mip with wdata 0 -> legal, rdata = 0x80 with mtip = 1. CSRRW mip -> csr_illegal = 1, no change. CSRRW addr 0x7C0 -> illegal. CSRRW mhartid -> illegal.
5. CSRRW mcycle = 0xFFFF_FFFE (XLEN=32), idle 3 cycles -> mcycle = 0x0000_0001, mcycleh incremented by 1. retire pulsed 5 times -> minstret = 5.
6. Same-cycle trap_valid + mret + CSRRW mscratch = 0x55 -> only the trap effects apply, mscratch unchanged. rst asserted during trap_valid -> all registers at reset values.

Source files
------------

// File: rtl/csr_unit.sv
// Machine-mode CSR file: CSRRW/RS/RC access with legality checks, trap entry/mret,
// interrupt request generation and 64-bit mcycle/minstret counters.
module csr_unit #(
    parameter int unsigned XLEN        = 32,
    parameter bit          VECTORED_EN = 1'b1,
    parameter int unsigned HART_ID     = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      csr_op,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_illegal,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_epc,
    input  logic [XLEN-1:0] trap_tval,
    input  logic            mret,
    input  logic            retire,
    input  logic            mtip,
    input  logic            meip,
    output logic [XLEN-1:0] trap_target,
    output logic [XLEN-1:0] mret_target,
    output logic            irq_req,
    output logic [XLEN-1:0] irq_cause
);

    localparam logic [11:0] AddrMstatus   = 12'h300;
    localparam logic [11:0] AddrMisa      = 12'h301;
    localparam logic [11:0] AddrMie       = 12'h304;
    localparam logic [11:0] AddrMtvec     = 12'h305;
    localparam logic [11:0] AddrMscratch  = 12'h340;
    localparam logic [11:0] AddrMepc      = 12'h341;
    localparam logic [11:0] AddrMcause    = 12'h342;
    localparam logic [11:0] AddrMtval     = 12'h343;
    localparam logic [11:0] AddrMip       = 12'h344;
    localparam logic [11:0] AddrMcycle    = 12'hB00;
    localparam logic [11:0] AddrMinstret  = 12'hB02;
    localparam logic [11:0] AddrMcycleh   = 12'hB80;
    localparam logic [11:0] AddrMinstreth = 12'hB82;
    localparam logic [11:0] AddrMhartid   = 12'hF14;

    localparam logic [XLEN-1:0] LowMask = ~XLEN'(3);

    logic            status_mie_q, status_mie_d;
    logic            status_mpie_q, status_mpie_d;
    logic [XLEN-1:0] mie_q, mie_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [XLEN-1:0] mtval_q, mtval_d;
    logic [63:0]     mcycle_q, mcycle_d;
    logic [63:0]     minstret_q, minstret_d;

    logic [XLEN-1:0] mstatus_val, misa_val, mip_val, old_val, new_val;
    logic            implemented, csr_write, read_only, wr_en;
    logic            ext_pend, tim_pend;

    always_comb begin
        mstatus_val        = '0;
        mstatus_val[12:11] = 2'b11;
        mstatus_val[7]     = status_mpie_q;
        mstatus_val[3]     = status_mie_q;
        misa_val           = '0;
        misa_val[XLEN-1:XLEN-2] = (XLEN == 32) ? 2'd1 : 2'd2;
        misa_val[8]        = 1'b1;
        mip_val            = '0;
        mip_val[7]         = mtip;
        mip_val[11]        = meip;
    end

    always_comb begin
        implemented = 1'b1;
        old_val     = '0;
        case (csr_addr)
            AddrMstatus:  old_val = mstatus_val;
            AddrMisa:     old_val = misa_val;
            AddrMie:      old_val = mie_q;
            AddrMtvec:    old_val = mtvec_q;
            AddrMscratch: old_val = mscratch_q;
            AddrMepc:     old_val = mepc_q;
            AddrMcause:   old_val = mcause_q;
            AddrMtval:    old_val = mtval_q;
            AddrMip:      old_val = mip_val;
            AddrMcycle:   old_val = XLEN'(mcycle_q);
            AddrMinstret: old_val = XLEN'(minstret_q);
            AddrMcycleh: begin
                if (XLEN == 32) old_val = XLEN'(mcycle_q[63:32]);
                else implemented = 1'b0;
            end
            AddrMinstreth: begin
                if (XLEN == 32) old_val = XLEN'(minstret_q[63:32]);
                else implemented = 1'b0;
            end
            AddrMhartid:  old_val = XLEN'(HART_ID);
            default:      implemented = 1'b0;
        endcase
    end

    // RS/RC with a zero mask only read, so they stay legal on read-only CSRs.
    assign csr_write   = (csr_op == 2'b01) || (csr_op[1] && (|csr_wdata));
    assign read_only   = (csr_addr[11:10] == 2'b11) || (csr_addr == AddrMisa) ||
                         (csr_addr == AddrMip);
    assign csr_illegal = (csr_op != 2'b00) && (!implemented || (csr_write && read_only));
    assign csr_rdata   = ((csr_op != 2'b00) && !csr_illegal) ? old_val : '0;
    assign wr_en       = csr_write && !csr_illegal && !trap_valid && !mret;

    always_comb begin
        case (csr_op)
            2'b01:   new_val = csr_wdata;
            2'b10:   new_val = old_val | csr_wdata;
            2'b11:   new_val = old_val & ~csr_wdata;
            default: new_val = old_val;
        endcase
    end

    always_comb begin
        status_mie_d  = status_mie_q;
        status_mpie_d = status_mpie_q;
        mie_d         = mie_q;
        mtvec_d       = mtvec_q;
        mscratch_d    = mscratch_q;
        mepc_d        = mepc_q;
        mcause_d      = mcause_q;
        mtval_d       = mtval_q;
        mcycle_d      = mcycle_q + 64'd1;
        minstret_d    = minstret_q + 64'(retire);
        if (trap_valid) begin
            mepc_d        = trap_epc & LowMask;
            mcause_d      = trap_cause;
            mtval_d       = trap_tval;
            status_mpie_d = status_mie_q;
            status_mie_d  = 1'b0;
        end else if (mret) begin
            status_mie_d  = status_mpie_q;
            status_mpie_d = 1'b1;
        end else if (wr_en) begin
            case (csr_addr)
                AddrMstatus: begin
                    status_mie_d  = new_val[3];
                    status_mpie_d = new_val[7];
                end
                AddrMie:      mie_d = new_val & XLEN'(12'h888);
                AddrMtvec: begin
                    // Reserved MODE encodings (2, 3) collapse to direct mode.
                    mtvec_d = new_val & LowMask;
                    if (VECTORED_EN && (new_val[1:0] == 2'b01)) mtvec_d[0] = 1'b1;
                end
                AddrMscratch: mscratch_d = new_val;
                AddrMepc:     mepc_d     = new_val & LowMask;
                AddrMcause:   mcause_d   = new_val;
                AddrMtval:    mtval_d    = new_val;
                // A written half takes the write; the other half neither carries nor changes.
                AddrMcycle:   mcycle_d = (XLEN == 32) ? {mcycle_q[63:32], new_val[31:0]}
                                                      : 64'(new_val);
                AddrMcycleh:  mcycle_d = {new_val[31:0], mcycle_q[31:0] + 32'd1};
                AddrMinstret: minstret_d = (XLEN == 32) ? {minstret_q[63:32], new_val[31:0]}
                                                        : 64'(new_val);
                AddrMinstreth: minstret_d = {new_val[31:0], minstret_q[31:0] + 32'(retire)};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_mie_q  <= 1'b0;
            status_mpie_q <= 1'b0;
            mie_q         <= '0;
            mtvec_q       <= '0;
            mscratch_q    <= '0;
            mepc_q        <= '0;
            mcause_q      <= '0;
            mtval_q       <= '0;
            mcycle_q      <= '0;
            minstret_q    <= '0;
        end else begin
            status_mie_q  <= status_mie_d;
            status_mpie_q <= status_mpie_d;
            mie_q         <= mie_d;
            mtvec_q       <= mtvec_d;
            mscratch_q    <= mscratch_d;
            mepc_q        <= mepc_d;
            mcause_q      <= mcause_d;
            mtval_q       <= mtval_d;
            mcycle_q      <= mcycle_d;
            minstret_q    <= minstret_d;
        end
    end

    always_comb begin
        trap_target = mtvec_q & LowMask;
        if ((mtvec_q[1:0] == 2'b01) && trap_cause[XLEN-1]) begin
            trap_target = (mtvec_q & LowMask) + {trap_cause[XLEN-3:0], 2'b00};
        end
    end

    assign mret_target = mepc_q;
    assign ext_pend    = mie_q[11] && meip;
    assign tim_pend    = mie_q[7] && mtip;
    assign irq_req     = status_mie_q && (ext_pend || tim_pend);

    always_comb begin
        irq_cause = '0;
        if (irq_req) begin
            irq_cause[XLEN-1] = 1'b1;
            irq_cause[3:0]    = ext_pend ? 4'd11 : 4'd7;
        end
    end

endmodule
